// File: rtl/inst_mem_ctrl_pkg.sv
// Shared definitions for the instruction-memory controller: default widths
// and the controller state encoding.
package inst_mem_ctrl_pkg;

  localparam int IMEM_ADDR_W_DEF = 10;
  localparam int INST_W_DEF      = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_START = 3'd2;
  localparam state_t ST_RUN   = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/inst_mem_ctrl_if.sv
// Bundle of the host load handshake, decoder control and decoder read port.
// The slave modport is the controller's view, master is the host/decoder side.
interface inst_mem_ctrl_if
  import inst_mem_ctrl_pkg::*;
#(
  parameter int IMEM_ADDR_W = IMEM_ADDR_W_DEF,
  parameter int INST_W      = INST_W_DEF
);

  logic [INST_W-1:0]      host_inst_data;
  logic                   host_inst_valid;
  logic                   host_inst_last;
  logic                   host_inst_ready;
  logic                   host_done;
  logic                   busy;
  logic [IMEM_ADDR_W:0]   inst_count;
  logic                   load_overflow;
  logic                   rd_oob;
  logic                   dec_start;
  logic                   dec_done;
  logic                   imem_read_req;
  logic [IMEM_ADDR_W-1:0] imem_read_addr;
  logic [INST_W-1:0]      imem_read_data;

  modport slave (
    input  host_inst_data, host_inst_valid, host_inst_last,
    input  dec_done, imem_read_req, imem_read_addr,
    output host_inst_ready, host_done, busy, inst_count,
    output load_overflow, rd_oob, dec_start, imem_read_data
  );

  modport master (
    output host_inst_data, host_inst_valid, host_inst_last,
    output dec_done, imem_read_req, imem_read_addr,
    input  host_inst_ready, host_done, busy, inst_count,
    input  load_overflow, rd_oob, dec_start, imem_read_data
  );

endinterface

// File: rtl/inst_mem_ctrl_imem_ram.sv
// Simple dual-port instruction RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
// Only the read register is reset; the array keeps whatever it held.
module imem_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Next read data: fetch on request, otherwise hold the previous word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  // Array write; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register; samples the array before this edge's write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction-memory controller: loads a program from the host, kicks the
// decoder, serves decoder reads and reports completion back to the host.
module inst_mem_ctrl
  import inst_mem_ctrl_pkg::*;
#(
  parameter int IMEM_ADDR_W = IMEM_ADDR_W_DEF,
  parameter int INST_W      = INST_W_DEF
) (
  input logic         clk,
  input logic         reset,
  inst_mem_ctrl_if.slave bus
);

  localparam logic [IMEM_ADDR_W-1:0] LAST_ADDR = '1;

  state_t                 state_q, state_d;
  logic [IMEM_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IMEM_ADDR_W:0]   count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   oob_q, oob_d;
  logic                   dec_start_q, dec_start_d;
  logic                   host_done_q, host_done_d;
  logic                   wr_en;
  logic [INST_W-1:0]      rd_data;

  // Controller sequencing, load bookkeeping and sticky error flags.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    oob_d       = oob_q;
    wr_en       = 1'b0;
    dec_start_d = (state_q == ST_START);
    host_done_d = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (bus.host_inst_valid) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          count_d  = '0;
          ovf_d    = 1'b0;
          oob_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (bus.host_inst_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (wr_ptr_q == LAST_ADDR) begin
            state_d = ST_START;
            if (!bus.host_inst_last) ovf_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (bus.host_inst_last) state_d = ST_START;
          end
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.dec_done) state_d = ST_DONE;
        if (bus.imem_read_req && ({1'b0, bus.imem_read_addr} >= count_q)) oob_d = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers; reset aborts any load or run in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      oob_q       <= 1'b0;
      dec_start_q <= 1'b0;
      host_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      oob_q       <= oob_d;
      dec_start_q <= dec_start_d;
      host_done_q <= host_done_d;
    end
  end

  imem_ram #(
    .ADDR_W (IMEM_ADDR_W),
    .DATA_W (INST_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.host_inst_data),
    .rd_en   (bus.imem_read_req),
    .rd_addr (bus.imem_read_addr),
    .rd_data (rd_data)
  );

  assign bus.host_inst_ready = (state_q == ST_LOAD);
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.host_done       = host_done_q;
  assign bus.dec_start       = dec_start_q;
  assign bus.inst_count      = count_q;
  assign bus.load_overflow   = ovf_q;
  assign bus.rd_oob          = oob_q;
  assign bus.imem_read_data  = rd_data;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Bench for inst_mem_ctrl: a default-size instance for the main flow and a
// 4-word instance for the overflow case, checked against a program model.
module tb_inst_mem_ctrl;

  localparam int AW  = 10;
  localparam int IW  = 32;
  localparam int AWS = 2;

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          chk_data;
    logic [IW-1:0] exp_data;
    logic          exp_oob;
  } rd_vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] model_mem [1024];
  bit            model_written [1024];
  int            model_count;
  bit            model_oob;

  rd_vec_t vecs [6];

  inst_mem_ctrl_if #(.IMEM_ADDR_W(AW),  .INST_W(IW)) bus ();
  inst_mem_ctrl_if #(.IMEM_ADDR_W(AWS), .INST_W(IW)) bus_s ();

  inst_mem_ctrl #(.IMEM_ADDR_W(AW), .INST_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  inst_mem_ctrl #(.IMEM_ADDR_W(AWS), .INST_W(IW)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one word and wait (bounded) for the handshake; the model records it.
  task automatic sendWord(input logic [IW-1:0] data, input logic last);
    bit acc = 1'b0;
    bus.host_inst_data  = data;
    bus.host_inst_valid = 1'b1;
    bus.host_inst_last  = last;
    for (int i = 0; i < 8 && !acc; i++) begin
      acc = bus.host_inst_ready;
      tick();
    end
    if (!acc) checkOutput("handshake_timeout", 64'd0, 64'd1);
    else begin
      model_mem[model_count]     = data;
      model_written[model_count] = 1'b1;
      model_count++;
    end
  endtask

  task automatic applyStimulus(input rd_vec_t v, input int idx);
    bus.imem_read_req  = v.req;
    bus.imem_read_addr = v.addr;
    tick();
    if (v.chk_data) checkOutput($sformatf("vec%0d_data", idx), bus.imem_read_data, v.exp_data);
    checkOutput($sformatf("vec%0d_oob", idx), bus.rd_oob, v.exp_oob);
  endtask

  // After the last handshake: START cycle, then the one-cycle dec_start pulse.
  task automatic expectStart(input string tag);
    checkOutput({tag, "_ready_low"}, bus.host_inst_ready, 1'b0);
    checkOutput({tag, "_start_early"}, bus.dec_start, 1'b0);
    tick();
    checkOutput({tag, "_dec_start"}, bus.dec_start, 1'b1);
    tick();
    checkOutput({tag, "_dec_start_off"}, bus.dec_start, 1'b0);
  endtask

  task automatic finishRun();
    bus.dec_done = 1'b1;
    tick();
    bus.dec_done = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [IW-1:0] old0;
    logic [IW-1:0] exp_data;
    bit            exp_known;
    bit            saw_start;
    int            n;
    int            addr;
    bit            acc;

    bus.host_inst_data = '0; bus.host_inst_valid = 0; bus.host_inst_last = 0;
    bus.dec_done = 0; bus.imem_read_req = 0; bus.imem_read_addr = '0;
    bus_s.host_inst_data = '0; bus_s.host_inst_valid = 0; bus_s.host_inst_last = 0;
    bus_s.dec_done = 0; bus_s.imem_read_req = 0; bus_s.imem_read_addr = '0;
    for (int i = 0; i < 1024; i++) model_written[i] = 1'b0;

    // Reset state
    #2 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_ready", bus.host_inst_ready, 1'b0);
    checkOutput("rst_count", bus.inst_count, 0);
    checkOutput("rst_dec_start", bus.dec_start, 1'b0);
    checkOutput("rst_host_done", bus.host_done, 1'b0);
    checkOutput("rst_ovf", bus.load_overflow, 1'b0);
    checkOutput("rst_oob", bus.rd_oob, 1'b0);
    checkOutput("rst_rdata", bus.imem_read_data, 0);
    checkOutput("rst_small_busy", bus_s.busy, 1'b0);

    // Program A: four words, last on the fourth
    model_count = 0; model_oob = 0;
    for (int i = 0; i < 4; i++) sendWord(32'h1000_0001 + i, i == 3);
    bus.host_inst_valid = 0; bus.host_inst_last = 0;
    checkOutput("A_count", bus.inst_count, model_count);
    checkOutput("A_busy", bus.busy, 1'b1);
    expectStart("A");

    // Table-driven reads in RUN, including the out-of-range boundary
    vecs[0] = '{1'b1, 10'd2, 1'b1, 32'h1000_0003, 1'b0};
    vecs[1] = '{1'b0, 10'd1, 1'b1, 32'h1000_0003, 1'b0};
    vecs[2] = '{1'b1, 10'd3, 1'b1, 32'h1000_0004, 1'b0};
    vecs[3] = '{1'b1, 10'd0, 1'b1, 32'h1000_0001, 1'b0};
    vecs[4] = '{1'b1, 10'd4, 1'b0, 32'h0,         1'b1};
    vecs[5] = '{1'b1, 10'd1, 1'b1, 32'h1000_0002, 1'b1};
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);
    bus.imem_read_req = 0;

    // Completion handshake
    bus.dec_done = 1'b1;
    tick();
    bus.dec_done = 1'b0;
    checkOutput("done_state_hd", bus.host_done, 1'b0);
    checkOutput("done_state_busy", bus.busy, 1'b1);
    tick();
    checkOutput("host_done_pulse", bus.host_done, 1'b1);
    checkOutput("idle_busy", bus.busy, 1'b0);
    tick();
    checkOutput("host_done_off", bus.host_done, 1'b0);
    checkOutput("count_retained", bus.inst_count, 4);

    // dec_done outside RUN is ignored; reads still served in IDLE
    bus.dec_done = 1'b1;
    tick();
    bus.dec_done = 1'b0;
    checkOutput("idle_dec_done_busy", bus.busy, 1'b0);
    tick();
    checkOutput("idle_dec_done_hd", bus.host_done, 1'b0);
    bus.imem_read_req = 1; bus.imem_read_addr = 10'd1;
    tick();
    bus.imem_read_req = 0;
    checkOutput("idle_read", bus.imem_read_data, model_mem[1]);

    // Program B: random words with gaps; first write collides with a read of 0
    n = $urandom_range(3, 8);
    old0 = model_mem[0];
    model_count = 0; model_oob = 0;
    bus.imem_read_req = 1; bus.imem_read_addr = '0;
    sendWord($urandom, 1'b0);
    bus.imem_read_req = 0;
    checkOutput("read_first", bus.imem_read_data, old0);
    checkOutput("B_oob_cleared", bus.rd_oob, 1'b0);
    checkOutput("B_count1", bus.inst_count, 1);
    for (int i = 1; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        bus.host_inst_valid = 0;
        for (int k = 0; k < int'($urandom_range(1, 2)); k++) tick();
      end
      sendWord($urandom, i == n - 1);
    end
    bus.host_inst_valid = 0; bus.host_inst_last = 0;
    checkOutput("B_count", bus.inst_count, model_count);
    expectStart("B");
    exp_data = old0; exp_known = 1'b1;
    for (int i = 0; i < 12; i++) begin
      addr = $urandom_range(0, n + 3);
      bus.imem_read_req  = ($urandom_range(0, 3) != 0);
      bus.imem_read_addr = AW'(addr);
      if (bus.imem_read_req) begin
        exp_known = model_written[addr];
        exp_data  = model_mem[addr];
        if (addr >= model_count) model_oob = 1'b1;
      end
      tick();
      if (exp_known) checkOutput($sformatf("B_rd%0d_data", i), bus.imem_read_data, exp_data);
      checkOutput($sformatf("B_rd%0d_oob", i), bus.rd_oob, model_oob);
    end
    bus.imem_read_req = 0;
    finishRun();

    // Reset in the middle of a load
    model_count = 0;
    sendWord(32'hAAAA_0000, 1'b0);
    sendWord(32'hAAAA_0001, 1'b0);
    checkOutput("C_pre_reset_count", bus.inst_count, 2);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_busy", bus.busy, 1'b0);
    checkOutput("mid_rst_ready", bus.host_inst_ready, 1'b0);
    checkOutput("mid_rst_count", bus.inst_count, 0);
    checkOutput("mid_rst_rdata", bus.imem_read_data, 0);
    bus.host_inst_valid = 0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) model_written[i] = 1'b0;
    saw_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.dec_start || bus.host_done) saw_start = 1'b1;
      tick();
    end
    checkOutput("no_pulse_after_rst", saw_start, 1'b0);
    model_count = 0;
    for (int i = 0; i < 3; i++) sendWord(32'hC000_0000 + i, i == 2);
    bus.host_inst_valid = 0; bus.host_inst_last = 0;
    checkOutput("C_count", bus.inst_count, 3);
    expectStart("C");
    bus.imem_read_req = 1; bus.imem_read_addr = '0;
    tick();
    bus.imem_read_req = 0;
    checkOutput("C_addr0", bus.imem_read_data, 32'hC000_0000);
    finishRun();

    // Overflow on the 4-word instance: no last flag ever sent
    for (int i = 0; i < 4; i++) begin
      bus_s.host_inst_data = 32'h2000_0000 + i;
      bus_s.host_inst_valid = 1; bus_s.host_inst_last = 0;
      acc = 1'b0;
      for (int j = 0; j < 8 && !acc; j++) begin
        acc = bus_s.host_inst_ready;
        tick();
      end
      if (!acc) checkOutput("S_handshake_timeout", 64'd0, 64'd1);
    end
    bus_s.host_inst_valid = 0;
    checkOutput("S_overflow", bus_s.load_overflow, 1'b1);
    checkOutput("S_count", bus_s.inst_count, 4);
    checkOutput("S_ready_low", bus_s.host_inst_ready, 1'b0);
    checkOutput("S_busy", bus_s.busy, 1'b1);
    tick();
    checkOutput("S_dec_start", bus_s.dec_start, 1'b1);
    bus_s.imem_read_req = 1; bus_s.imem_read_addr = 2'd0;
    tick();
    checkOutput("S_addr0", bus_s.imem_read_data, 32'h2000_0000);
    bus_s.imem_read_addr = 2'd3;
    tick();
    bus_s.imem_read_req = 0;
    checkOutput("S_addr3", bus_s.imem_read_data, 32'h2000_0003);
    checkOutput("S_no_oob", bus_s.rd_oob, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
